// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the rv32imc pipeline stages and the stall/flush sequencer.
// The master side reports stage status; the slave side (sequencer) returns stall/bubble controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_muldiv_valid;
  logic             ex_redirect;
  logic             muldiv_done;
  logic             mem_dmem_req;
  logic             dmem_resp;

  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_id;
  logic             bubble_ex;
  logic             bubble_mem;
  logic             bubble_wb;
  logic             muldiv_start;
  logic             muldiv_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, ex_rd_addr,
           ex_mem_read, ex_muldiv_valid, ex_redirect, muldiv_done,
           mem_dmem_req, dmem_resp,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
           bubble_mem, bubble_wb, muldiv_start, muldiv_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, ex_rd_addr,
           ex_mem_read, ex_muldiv_valid, ex_redirect, muldiv_done,
           mem_dmem_req, dmem_resp,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
           bubble_mem, bubble_wb, muldiv_start, muldiv_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32imc pipeline: prioritised hazard resolution,
// mul/div start/done handshake with timeout watchdog, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MD_MAX_CYC = 34,
  parameter int CNT_W      = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int MD_W = $clog2(MD_MAX_CYC + 1);

  typedef enum logic [0:0] {RUN, MD_BUSY} state_t;

  state_t           state, state_d;
  logic             done_pend;
  logic [MD_W-1:0]  md_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic dmem_hz, md_ready, md_hz, lu_hz;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [MD_W-1:0] sat_inc_md(input logic [MD_W-1:0] v);
    return (&v) ? v : v + MD_W'(1);
  endfunction

  assign dmem_hz  = hz.mem_dmem_req & ~hz.dmem_resp;
  assign md_ready = hz.muldiv_done | done_pend;
  assign md_hz    = hz.ex_muldiv_valid & ~md_ready;
  assign lu_hz    = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
                    ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                     (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

  assign hz.muldiv_timeout = timeout_q;
  assign hz.stall_cycles   = stall_cycles_q;

  always_comb begin
    hz.stall_if     = 1'b0;
    hz.stall_id     = 1'b0;
    hz.stall_ex     = 1'b0;
    hz.stall_mem    = 1'b0;
    hz.flush_id     = 1'b0;
    hz.bubble_ex    = 1'b0;
    hz.bubble_mem   = 1'b0;
    hz.bubble_wb    = 1'b0;
    hz.muldiv_start = 1'b0;
    state_d         = state;
    if (rst_n) begin
      // Only the highest-priority active hazard shapes the controls.
      if (dmem_hz) begin
        hz.stall_if  = 1'b1;
        hz.stall_id  = 1'b1;
        hz.stall_ex  = 1'b1;
        hz.stall_mem = 1'b1;
        hz.bubble_wb = 1'b1;
      end else if (md_hz) begin
        hz.stall_if   = 1'b1;
        hz.stall_id   = 1'b1;
        hz.stall_ex   = 1'b1;
        hz.bubble_mem = 1'b1;
      end else if (hz.ex_redirect) begin
        hz.flush_id  = 1'b1;
        hz.bubble_ex = 1'b1;
      end else if (lu_hz) begin
        hz.stall_if  = 1'b1;
        hz.stall_id  = 1'b1;
        hz.bubble_ex = 1'b1;
      end

      unique case (state)
        RUN: begin
          if (hz.ex_muldiv_valid) begin
            hz.muldiv_start = 1'b1;
            state_d         = MD_BUSY;
          end
        end
        MD_BUSY: begin
          // A done that lands under a DMEM stall is held in done_pend until MEM frees up.
          if (!hz.ex_muldiv_valid || (md_ready && !dmem_hz)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      done_pend      <= 1'b0;
      md_cnt         <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state <= state_d;
      if (hz.stall_if) stall_cycles_q <= sat_inc_cnt(stall_cycles_q);
      if (state == RUN) begin
        done_pend <= 1'b0;
        md_cnt    <= '0;
      end else if (state_d == RUN) begin
        done_pend <= 1'b0;
      end else begin
        md_cnt <= sat_inc_md(md_cnt);
        if (hz.muldiv_done && dmem_hz) done_pend <= 1'b1;
        // Watchdog only flags; the MULDIV stall keeps holding the pipeline.
        if (!md_ready && (sat_inc_md(md_cnt) == MD_W'(MD_MAX_CYC))) timeout_q <= 1'b1;
      end
    end
  end
endmodule
